uart_tx_arbiter: RTL and testbench

Shares the single UART byte transmitter between several byte producers: the solution assembler and the status/ack reporter. Holds one pending byte per requester and grants the transmitter round-robin at packet boundaries. Once a requester is granted, it is locked in until its last-flagged byte completes, so multi-byte messages (m, n, rows, stop) are never interleaved. Sits between the producers and the UART TX; it relays the transmitter's per-byte done pulse back to the owning requester.

---
 rtl/uart_tx_arb_pkg.sv | 19 +
 rtl/uart_tx_arbiter_if.sv | 30 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types for the UART transmit arbiter: byte width, arbiter FSM states
// and the per-requester pending-slot layout.
package uart_tx_arb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic              last;
        logic              valid;
    } slot_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer/transmitter-side bundle of the UART transmit arbiter.
// The master side is the producers plus the UART TX; the slave side is the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int BYTE_W  = 8
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             req_send;
    logic [NUM_REQ-1:0][BYTE_W-1:0] req_byte;
    logic [NUM_REQ-1:0]             req_last;
    logic [NUM_REQ-1:0]             req_done;
    logic                           tx_send;
    logic [BYTE_W-1:0]              tx_byte;
    logic                           tx_done;
    logic [IDX_W-1:0]               grant;
    logic                           locked;
    logic [NUM_REQ-1:0]             overflow;

    modport master (
        output req_send, req_byte, req_last, tx_done,
        input  req_done, tx_send, tx_byte, grant, locked, overflow
    );

    modport slave (
        input  req_send, req_byte, req_last, tx_done,
        output req_done, tx_send, tx_byte, grant, locked, overflow
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of i_valid at or after
// i_start, wrapping modulo N.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_valid,
    input  logic [IDX_W-1:0] i_start,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    // Walk the offsets from the start pointer; the first hit wins.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_start} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N)) begin
                w_sum = w_sum - (IDX_W+1)'(N);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!o_found && i_valid[w_cand]) begin
                o_idx   = w_cand;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter among NUM_REQ producers; grants round-robin
// at packet boundaries and holds the owner until its last-flagged byte is done.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int BYTE_W  = uart_tx_arb_pkg::BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);
    import uart_tx_arb_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e         r_state;
    slot_t              r_slot [NUM_REQ];
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   r_rrPtr;
    logic               r_curLast;
    logic               r_locked;
    logic               r_txSend;
    logic [BYTE_W-1:0]  r_txByte;
    logic [NUM_REQ-1:0] r_reqDone;
    logic [NUM_REQ-1:0] r_overflow;

    logic [NUM_REQ-1:0] w_validVec;
    logic [NUM_REQ-1:0] w_grantOneHot;
    logic [NUM_REQ-1:0] w_eligible;
    logic [NUM_REQ-1:0] w_issueClear;
    logic [IDX_W-1:0]   w_pickIdx;
    logic               w_pickFound;

    function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] idx);
        return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
    endfunction

    // While a packet is open only the owner may be picked; the slot being
    // emptied in ISSUE is treated as free so a same-cycle send refills it.
    always_comb begin
        w_validVec    = '0;
        w_grantOneHot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_validVec[i] = r_slot[i].valid;
        end
        w_grantOneHot[r_grant] = 1'b1;
        w_eligible   = r_locked ? (w_validVec & w_grantOneHot) : w_validVec;
        w_issueClear = (r_state == ISSUE) ? w_grantOneHot : '0;
    end

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rrPick (
        .i_valid (w_eligible),
        .i_start (r_rrPtr),
        .o_idx   (w_pickIdx),
        .o_found (w_pickFound)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_rrPtr    <= '0;
            r_curLast  <= 1'b0;
            r_locked   <= 1'b0;
            r_txSend   <= 1'b0;
            r_txByte   <= '0;
            r_reqDone  <= '0;
            r_overflow <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            r_txSend  <= 1'b0;
            r_reqDone <= '0;

            // tx_send is raised on entry to ISSUE so it is high during that state.
            case (r_state)
                IDLE: begin
                    if (w_pickFound) begin
                        r_grant  <= w_pickIdx;
                        r_txSend <= 1'b1;
                        r_txByte <= r_slot[w_pickIdx].data;
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_slot[r_grant].valid <= 1'b0;
                    r_curLast             <= r_slot[r_grant].last;
                    r_locked              <= !r_slot[r_grant].last;
                    r_state               <= WAIT;
                end
                WAIT: begin
                    if (bus.tx_done) begin
                        r_reqDone[r_grant] <= 1'b1;
                        if (r_curLast) begin
                            r_locked <= 1'b0;
                            r_rrPtr  <= nextIdx(r_grant);
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Placed after the FSM so a capture overrides the ISSUE clear.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_send[i]) begin
                    if (r_slot[i].valid && !w_issueClear[i]) begin
                        r_overflow[i] <= 1'b1;
                    end else begin
                        r_slot[i] <= '{data: bus.req_byte[i], last: bus.req_last[i], valid: 1'b1};
                    end
                end
            end
        end
    end

    assign bus.tx_send  = r_txSend;
    assign bus.tx_byte  = r_txByte;
    assign bus.req_done = r_reqDone;
    assign bus.grant    = r_grant;
    assign bus.locked   = r_locked;
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: expected transmissions are queued as
// stimulus is issued and a negedge monitor checks every tx_send against them.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 2;
    localparam int BYTE_W  = 8;

    typedef struct {
        int               req;
        logic [BYTE_W-1:0] data;
    } expTx_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .BYTE_W(BYTE_W)) busIf ();

    uart_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .BYTE_W  (BYTE_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf)
    );

    expTx_t expQ[$];
    expTx_t monEntry;
    int     testCount = 0;
    int     failCount = 0;
    int     sentCount = 0;
    int     txTarget  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushExp(input int req, input logic [BYTE_W-1:0] data);
        expTx_t e;
        e.req  = req;
        e.data = data;
        expQ.push_back(e);
    endtask

    // Each tx_send pulse must match the oldest expected transmission.
    always @(negedge clk) begin
        if (rst === 1'b1 && busIf.tx_send === 1'b1) begin
            sentCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpectedTxSend", 32'd1, 32'd0);
            end else begin
                monEntry = expQ.pop_front();
                checkOutput("txByte", 32'(busIf.tx_byte), 32'(monEntry.data));
                checkOutput("txGrant", 32'(busIf.grant), 32'(monEntry.req));
            end
        end
    end

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] send, input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [1:0] last);
        busIf.req_send    = send;
        busIf.req_byte[0] = b0;
        busIf.req_byte[1] = b1;
        busIf.req_last    = last;
        @(posedge clk);
        #1;
        busIf.req_send = '0;
        busIf.req_last = '0;
    endtask

    task automatic pulseDone();
        busIf.tx_done = 1'b1;
        @(posedge clk);
        #1;
        busIf.tx_done = 1'b0;
    endtask

    task automatic waitTxSend();
        txTarget++;
        for (int c = 0; c < 20; c++) begin
            if (sentCount >= txTarget) break;
            @(posedge clk);
            #1;
        end
        checkOutput("txSendSeen", 32'(sentCount >= txTarget), 32'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_txSend"},   32'(busIf.tx_send),  32'd0);
        checkOutput({tag, "_txByte"},   32'(busIf.tx_byte),  32'd0);
        checkOutput({tag, "_reqDone"},  32'(busIf.req_done), 32'd0);
        checkOutput({tag, "_grant"},    32'(busIf.grant),    32'd0);
        checkOutput({tag, "_locked"},   32'(busIf.locked),   32'd0);
        checkOutput({tag, "_overflow"}, 32'(busIf.overflow), 32'd0);
    endtask

    task automatic doReset();
        rst            = 1'b0;
        busIf.req_send = '0;
        busIf.req_byte = '0;
        busIf.req_last = '0;
        busIf.tx_done  = 1'b0;
        stepCycles(2);
        checkResetOutputs("reset");
        rst = 1'b1;
        stepCycles(1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Single byte, checking the two-edge issue latency.
        doReset();
        pushExp(0, 8'h03);
        applyStimulus(2'b01, 8'h03, 8'h00, 2'b01);
        stepCycles(1);
        checkOutput("issueLatency", 32'(busIf.tx_send), 32'd1);
        waitTxSend();
        checkOutput("singleLocked", 32'(busIf.locked), 32'd0);
        pulseDone();
        checkOutput("singleDone", 32'(busIf.req_done), 32'b01);
        stepCycles(1);
        checkOutput("donePulseOnce", 32'(busIf.req_done), 32'b00);

        // Packet lock: requester 1's byte waits until requester 0 finishes its packet.
        doReset();
        pushExp(0, 8'h03);
        applyStimulus(2'b11, 8'h03, 8'hAA, 2'b10);
        waitTxSend();
        checkOutput("lockSet", 32'(busIf.locked), 32'd1);
        pulseDone();
        checkOutput("lockDone0", 32'(busIf.req_done), 32'b01);
        stepCycles(3);
        checkOutput("lockHolds", 32'(sentCount), 32'(txTarget));
        checkOutput("lockStill", 32'(busIf.locked), 32'd1);
        pushExp(0, 8'h05);
        pushExp(1, 8'hAA);
        applyStimulus(2'b01, 8'h05, 8'h00, 2'b01);
        waitTxSend();
        checkOutput("lockReleased", 32'(busIf.locked), 32'd0);
        pulseDone();
        checkOutput("lockDone0b", 32'(busIf.req_done), 32'b01);
        waitTxSend();
        pulseDone();
        checkOutput("lockDone1", 32'(busIf.req_done), 32'b10);
        checkOutput("lockGrant1", 32'(busIf.grant), 32'd1);

        // Round robin with both requesters always holding a last byte.
        doReset();
        pushExp(0, 8'h10);
        pushExp(1, 8'h20);
        pushExp(0, 8'h12);
        pushExp(1, 8'h22);
        applyStimulus(2'b11, 8'h10, 8'h20, 2'b11);
        waitTxSend();
        applyStimulus(2'b01, 8'h12, 8'h00, 2'b01);
        pulseDone();
        waitTxSend();
        applyStimulus(2'b10, 8'h00, 8'h22, 2'b10);
        pulseDone();
        waitTxSend();
        pulseDone();
        waitTxSend();
        pulseDone();
        checkOutput("rrDone1", 32'(busIf.req_done), 32'b10);

        // Overflow: second byte from requester 1 is dropped while requester 0 holds the lock.
        doReset();
        pushExp(0, 8'h03);
        applyStimulus(2'b01, 8'h03, 8'h00, 2'b00);
        waitTxSend();
        applyStimulus(2'b10, 8'h00, 8'h11, 2'b10);
        checkOutput("noOverflowYet", 32'(busIf.overflow), 32'b00);
        applyStimulus(2'b10, 8'h00, 8'h22, 2'b10);
        checkOutput("overflowSet", 32'(busIf.overflow), 32'b10);
        pulseDone();
        stepCycles(2);
        checkOutput("ovfBlocked", 32'(sentCount), 32'(txTarget));
        pushExp(0, 8'h05);
        pushExp(1, 8'h11);
        applyStimulus(2'b01, 8'h05, 8'h00, 2'b01);
        waitTxSend();
        pulseDone();
        waitTxSend();
        pulseDone();
        checkOutput("ovfDone1", 32'(busIf.req_done), 32'b10);
        stepCycles(4);
        checkOutput("droppedNeverSent", 32'(sentCount), 32'(txTarget));
        checkOutput("overflowSticky", 32'(busIf.overflow), 32'b10);

        // Set wins: a send during the owner's own ISSUE cycle is kept without overflow.
        doReset();
        pushExp(0, 8'h40);
        pushExp(0, 8'h41);
        applyStimulus(2'b01, 8'h40, 8'h00, 2'b01);
        stepCycles(1);
        checkOutput("setWinsIssue", 32'(busIf.tx_send), 32'd1);
        applyStimulus(2'b01, 8'h41, 8'h00, 2'b01);
        waitTxSend();
        checkOutput("setWinsNoOvf", 32'(busIf.overflow), 32'b00);
        pulseDone();
        checkOutput("setWinsDone", 32'(busIf.req_done), 32'b01);
        waitTxSend();
        pulseDone();
        checkOutput("setWinsDone2", 32'(busIf.req_done), 32'b01);

        // Reset in the middle of WAIT aborts the packet; a late tx_done is ignored.
        pushExp(1, 8'h55);
        applyStimulus(2'b10, 8'h00, 8'h55, 2'b00);
        waitTxSend();
        checkOutput("preResetGrant", 32'(busIf.grant), 32'd1);
        checkOutput("preResetLocked", 32'(busIf.locked), 32'd1);
        rst = 1'b0;
        stepCycles(1);
        checkResetOutputs("midReset");
        rst = 1'b1;
        pulseDone();
        checkOutput("lateDoneIgnored", 32'(busIf.req_done), 32'b00);
        stepCycles(3);
        checkOutput("noSendAfterReset", 32'(sentCount), 32'(txTarget));

        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
